// File: rtl/nibble_add_pkg.sv
// nibble_add_pkg: shared constants, state encoding and width check for the nibble adder sequencer
package nibble_add_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  function automatic bit width_ok(input int w);
    return (w % NIBBLE_W == 0) && (w >= NIBBLE_W);
  endfunction
endpackage

// File: rtl/nibble_add_seq_fa4b.sv
// fa4b: 4-bit adder with carry in and carry out
module fa4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = 5'(a) + 5'(b) + 5'(cin);
endmodule

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: WIDTH-bit add performed one nibble per clock through a single fa4b,
// with the inter-nibble carry held in a register.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("nibble_add_seq: WIDTH must be a positive multiple of 4");
  end
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [NIB-1:0][NIBBLE_W-1:0] a_lat, b_lat, sum_r;
  logic carry, ovf_r, c, last;
  logic [NIBBLE_W-1:0] s;
  assign last = idx == IW'(NIB - 1);
  fa4b u_fa (.a(a_lat[idx]), .b(b_lat[idx]), .cin(carry), .s(s), .cout(c));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == S_IDLE && in_valid) state_nx = S_RUN;
    else if (state == S_RUN && last) state_nx = S_DONE;
    else if (state == S_DONE && out_ready) state_nx = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      a_lat <= '0;
      b_lat <= '0;
      sum_r <= '0;
      ovf_r <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      a_lat <= a;
      b_lat <= b;
      carry <= cin;
      idx   <= '0;
    end else if (state == S_RUN) begin
      sum_r[idx] <= s;
      carry      <= c;
      idx        <= idx + 1'b1;
      // final nibble's adder MSB is the result MSB
      if (last) ovf_r <= (a_lat[NIB-1][3] == b_lat[NIB-1][3]) && (s[3] != a_lat[NIB-1][3]);
    end
  assign in_ready  = rst_n && state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign busy      = state != S_IDLE;
  assign sum       = sum_r;
  assign cout      = carry;
  assign ovf       = ovf_r;
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: directed self-checking bench for nibble_add_seq (WIDTH=16)
module tb_nibble_add_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, cin = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic        out_valid, out_ready = 1'b0, cout, ovf, busy;
  int checks = 0, failures = 0;

  nibble_add_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // issue at a negedge, accept on the next posedge; returns edges to out_valid
  task automatic issue_and_wait(input logic [15:0] ta, tb, input logic tc, output int lat);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL issue_in_ready got=%b exp=1", in_ready); end
    a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin lat = n; break; end
    end
  endtask

  task automatic do_op(input string nm, input logic [15:0] ta, tb, input logic tc,
                       input logic [15:0] es, input logic ec, eo);
    int lat;
    issue_and_wait(ta, tb, tc, lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL %s_latency got=%0d exp=4", nm, lat); end
    checks++;
    if (sum !== es || cout !== ec || ovf !== eo) begin
      failures++;
      $display("FAIL %s_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b", nm, sum, cout, ovf, es, ec, eo);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL %s_handoff got out_valid=%b in_ready=%b exp 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b busy=%b exp all 0",
               in_ready, out_valid, sum, cout, ovf, busy);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add;
    do_op("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("cin_add",    16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    do_op("all_ones",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
  endtask

  task automatic test_overflow;
    do_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure;
    int lat;
    issue_and_wait(16'h1111, 16'h2222, 1'b0, lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || sum !== 16'h3333 || cout !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold_%0d got out_valid=%b sum=%h cout=%b in_ready=%b busy=%b exp 1/3333/0/0/1",
                 i, out_valid, sum, cout, in_ready, busy);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_busy_reject;
    int lat;
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL busy_in_ready got=%b exp=0", in_ready); end
    a = 16'h0F0F; b = 16'h0F0F; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin lat = n; break; end
    end
    checks++;
    if (lat != 3 || sum !== 16'h0002 || cout !== 1'b0) begin
      failures++; $display("FAIL busy_result got lat=%0d sum=%h cout=%b exp lat=3 sum=0002 cout=0", lat, sum, cout);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL busy_no_second_%0d got out_valid=%b busy=%b exp 0/0", i, out_valid, busy);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || busy !== 1'b0 || in_ready !== 1'b0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got out_valid=%b sum=%h busy=%b in_ready=%b cout=%b exp 0/0000/0/0/0",
               out_valid, sum, busy, in_ready, cout);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    do_op("after_reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_add;
    test_overflow;
    test_backpressure;
    test_busy_reject;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
